// File: rtl/data_mem_if.sv
// data_mem_if: RV32I data-memory interface between execute and a variable-latency memory.
// Latency: a zero-wait load takes 4 cycles (3 stall cycles); a zero-wait store takes 3 cycles.
//   Each extra wait cycle on mem_gnt or mem_rvalid adds one stall cycle.
// Backpressure: Stall freezes the core while a request waits for mem_gnt or mem_rvalid.
//   mem_req and the request fields are held stable until mem_gnt is seen.
// Ports:
//   core side   : MemRead, MemWrite, ALUResult, WriteData, funct3 in; Stall, MemFault out
//   load extend : ReadData, offset, LoadExtSrc (registered, held until the next accepted access)
//   memory side : mem_req, mem_we, mem_addr, mem_be, mem_wdata out; mem_gnt, mem_rvalid, mem_rdata in
module data_mem_if (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic [2:0]  funct3,
  output logic        Stall,
  output logic        MemFault,
  output logic [31:0] ReadData,
  output logic [1:0]  offset,
  output logic [2:0]  LoadExtSrc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  state_t      state;
  logic        access;
  logic        legal_f3;
  logic        misaligned;
  logic        fault;
  logic        start;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  // Access decode: funct3[1:0] encodes the size (byte, half, word) for loads and stores.
  always_comb begin
    access     = MemRead | MemWrite;
    legal_f3   = 1'b0;
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = WriteData;

    if (MemWrite) begin
      legal_f3 = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010);
    end else begin
      legal_f3 = (funct3 == 3'b000) | (funct3 == 3'b001) | (funct3 == 3'b010) |
                 (funct3 == 3'b100) | (funct3 == 3'b101);
    end

    case (funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << ALUResult[1:0];
        wdata_next = {4{WriteData[7:0]}};
      end
      2'b01: begin
        misaligned = ALUResult[0];
        be_next    = ALUResult[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{WriteData[15:0]}};
      end
      default: begin
        misaligned = (ALUResult[1:0] != 2'b00);
        be_next    = 4'b1111;
        wdata_next = WriteData;
      end
    endcase

    fault    = access & (~legal_f3 | misaligned);
    MemFault = (state == IDLE) & fault;
    start    = (state == IDLE) & access & ~fault;
    Stall    = start | (state == REQ) | (state == RSP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_be     <= 4'h0;
      mem_wdata  <= 32'h0;
      ReadData   <= 32'h0;
      offset     <= 2'b00;
      LoadExtSrc <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= REQ;
            mem_req    <= 1'b1;
            mem_we     <= MemWrite;
            mem_addr   <= {ALUResult[31:2], 2'b00};
            mem_be     <= be_next;
            mem_wdata  <= wdata_next;
            offset     <= ALUResult[1:0];
            LoadExtSrc <= funct3;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state <= DONE;
            end else if (mem_rvalid) begin
              // Memory answered in the grant cycle: skip RSP entirely.
              ReadData <= mem_rdata;
              state    <= DONE;
            end else begin
              state <= RSP;
            end
          end
        end
        RSP: begin
          if (mem_rvalid) begin
            ReadData <= mem_rdata;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_if.sv
module tb_data_mem_if;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] ALUResult, WriteData;
  logic [2:0]  funct3;
  logic        Stall, MemFault;
  logic [31:0] ReadData;
  logic [1:0]  offset;
  logic [2:0]  LoadExtSrc;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  // Reference state: what the interface should be presenting to the load extender / memory.
  logic [31:0] m_rdata;
  logic [1:0]  m_off;
  logic [2:0]  m_lext;
  logic [31:0] m_addr;

  data_mem_if dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUResult(ALUResult), .WriteData(WriteData), .funct3(funct3),
    .Stall(Stall), .MemFault(MemFault), .ReadData(ReadData), .offset(offset),
    .LoadExtSrc(LoadExtSrc), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic int acc_size(input logic [2:0] f3);
    logic [1:0] s;
    s = f3[1:0];
    return 1 << s;
  endfunction

  function automatic bit is_fault(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    logic [1:0] lo;
    if (!(rd | wr)) return 1'b0;
    if (wr) legal = (f3 <= 3'd2);
    else    legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
    if (!legal) return 1'b1;
    lo = a[1:0];
    return (int'(lo) % acc_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] be;
    int off;
    logic [1:0] lo;
    lo = a[1:0];
    off = int'(lo);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + acc_size(f3));
    return be;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % acc_size(f3)) +: 8];
    return w;
  endfunction

  // One full instruction from its IDLE cycle to its DONE cycle; gw/rw are extra wait cycles.
  task automatic do_access(input string nm, input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [2:0] f3, input int gw, input int rw,
                           input bit same, input logic [31:0] rdata);
    bit flt;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    @(negedge clk);
    checks++; if (ReadData !== m_rdata) begin failures++; $display("FAIL %s hold_rdata got=%h exp=%h", nm, ReadData, m_rdata); end
    checks++; if (offset !== m_off || LoadExtSrc !== m_lext) begin failures++; $display("FAIL %s hold_off got=%0d/%b exp=%0d/%b", nm, offset, LoadExtSrc, m_off, m_lext); end
    MemRead = rd; MemWrite = wr; ALUResult = addr; WriteData = wd; funct3 = f3;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
    #1;
    flt = is_fault(rd, wr, f3, addr);
    checks++; if (MemFault !== flt) begin failures++; $display("FAIL %s memfault got=%b exp=%b", nm, MemFault, flt); end
    checks++; if (Stall !== ((rd | wr) & !flt)) begin failures++; $display("FAIL %s idle_stall got=%b exp=%b", nm, Stall, (rd | wr) & !flt); end
    if (!(rd | wr) || flt) begin
      @(negedge clk);
      checks++; if (mem_req !== 1'b0 || Stall !== 1'b0) begin failures++; $display("FAIL %s no_req got req=%b stall=%b exp 0/0", nm, mem_req, Stall); end
      checks++; if (MemFault !== flt) begin failures++; $display("FAIL %s stay_idle memfault got=%b exp=%b", nm, MemFault, flt); end
      checks++; if (mem_addr !== m_addr) begin failures++; $display("FAIL %s addr_held got=%h exp=%h", nm, mem_addr, m_addr); end
      MemRead = 1'b0; MemWrite = 1'b0;
      return;
    end
    ebe = ref_be(f3, addr);
    ewd = ref_wdata(f3, wd);
    m_addr = {addr[31:2], 2'b00};
    m_off  = addr[1:0];
    m_lext = f3;
    for (int k = 0; k <= gw; k++) begin
      @(negedge clk);
      checks++; if (mem_req !== 1'b1 || Stall !== 1'b1) begin failures++; $display("FAIL %s req_cyc%0d got req=%b stall=%b exp 1/1", nm, k, mem_req, Stall); end
      checks++; if (mem_addr !== m_addr || mem_be !== ebe) begin failures++; $display("FAIL %s addr_be got=%h/%b exp=%h/%b", nm, mem_addr, mem_be, m_addr, ebe); end
      checks++; if (mem_we !== wr || (wr && mem_wdata !== ewd)) begin failures++; $display("FAIL %s we_wdata got=%b/%h exp=%b/%h", nm, mem_we, mem_wdata, wr, ewd); end
      checks++; if (offset !== m_off || LoadExtSrc !== m_lext) begin failures++; $display("FAIL %s capture_off got=%0d/%b exp=%0d/%b", nm, offset, LoadExtSrc, m_off, m_lext); end
      mem_gnt = (k == gw);
      if (k == gw && rd && same) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
    end
    if (rd && !same) begin
      for (int k = 0; k <= rw; k++) begin
        @(negedge clk);
        mem_gnt = 1'b0;
        checks++; if (mem_req !== 1'b0 || Stall !== 1'b1) begin failures++; $display("FAIL %s rsp_cyc%0d got req=%b stall=%b exp 0/1", nm, k, mem_req, Stall); end
        mem_rvalid = (k == rw);
        mem_rdata  = (k == rw) ? rdata : $urandom;
      end
    end
    if (rd) m_rdata = rdata;
    @(negedge clk);
    mem_gnt = 1'b0;
    checks++; if (Stall !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL %s done got stall=%b req=%b exp 0/0", nm, Stall, mem_req); end
    checks++; if (ReadData !== m_rdata) begin failures++; $display("FAIL %s done_rdata got=%h exp=%h", nm, ReadData, m_rdata); end
    checks++; if (offset !== m_off || LoadExtSrc !== m_lext) begin failures++; $display("FAIL %s done_off got=%0d/%b exp=%0d/%b", nm, offset, LoadExtSrc, m_off, m_lext); end
    // Stray response in DONE must not be captured.
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_rdata  = $urandom;
  endtask

  task automatic test_reset;
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; ALUResult = 32'h0; WriteData = 32'h0;
    funct3 = 3'b000; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin
      failures++; $display("FAIL reset_mem got req=%b we=%b addr=%h be=%b wd=%h exp all 0", mem_req, mem_we, mem_addr, mem_be, mem_wdata); end
    checks++; if (ReadData !== 32'h0 || offset !== 2'b0 || LoadExtSrc !== 3'b0) begin
      failures++; $display("FAIL reset_load got rd=%h off=%0d lext=%b exp 0", ReadData, offset, LoadExtSrc); end
    checks++; if (Stall !== 1'b0 || MemFault !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b/%b exp 0/0", Stall, MemFault); end
    m_rdata = 32'h0; m_off = 2'b0; m_lext = 3'b0; m_addr = 32'h0;
    reset = 1'b0;
  endtask

  task automatic test_load_store;
    do_access("lw_0x100", 1, 0, 32'h100, 32'h0, 3'b010, 0, 0, 0, 32'hDEADBEEF);
    do_access("sb_0x203", 0, 1, 32'h203, 32'h12345678, 3'b000, 2, 0, 0, 32'h0);
    do_access("sh_0x302", 0, 1, 32'h302, 32'h0000ABCD, 3'b001, 0, 0, 0, 32'h0);
    do_access("lhu_0x302", 1, 0, 32'h302, 32'h0, 3'b101, 1, 2, 0, 32'hCAFEF00D);
    do_access("sh_0x300", 0, 1, 32'h300, 32'h9876_5432, 3'b001, 0, 0, 0, 32'h0);
    do_access("lb_0x001", 1, 0, 32'h001, 32'h0, 3'b000, 0, 3, 0, 32'h11223344);
  endtask

  task automatic test_fault;
    do_access("lw_mis", 1, 0, 32'h101, 32'h0, 3'b010, 0, 0, 0, 32'h0);
    do_access("lh_mis", 1, 0, 32'h103, 32'h0, 3'b001, 0, 0, 0, 32'h0);
    do_access("ld_f3_011", 1, 0, 32'h100, 32'h0, 3'b011, 0, 0, 0, 32'h0);
    do_access("sw_mis", 0, 1, 32'h102, 32'h5, 3'b010, 0, 0, 0, 32'h0);
    do_access("st_f3_100", 0, 1, 32'h100, 32'h5, 3'b100, 0, 0, 0, 32'h0);
    do_access("no_access", 0, 0, 32'h103, 32'h5, 3'b111, 0, 0, 0, 32'h0);
  endtask

  task automatic test_same_cycle;
    do_access("ld_same", 1, 0, 32'h400, 32'h0, 3'b010, 0, 0, 1, 32'h00FF00FF);
    do_access("ld_same_w", 1, 0, 32'h406, 32'h0, 3'b001, 2, 0, 1, 32'hA5A5_5A5A);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; ALUResult = 32'h100; funct3 = 3'b010;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checks++; if (Stall !== 1'b1) begin failures++; $display("FAIL rst_mid_rsp got stall=%b exp 1", Stall); end
    reset = 1'b1; MemRead = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_be !== 4'h0 || offset !== 2'b0 || LoadExtSrc !== 3'b0) begin
      failures++; $display("FAIL rst_mid_vals got req=%b addr=%h be=%b off=%0d lext=%b exp 0", mem_req, mem_addr, mem_be, offset, LoadExtSrc); end
    mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++; if (ReadData !== 32'h0 || Stall !== 1'b0) begin failures++; $display("FAIL rst_mid_late got rd=%h stall=%b exp 0/0", ReadData, Stall); end
    m_rdata = 32'h0; m_off = 2'b0; m_lext = 3'b0; m_addr = 32'h0;
  endtask

  task automatic test_random;
    logic [2:0] legal_ld [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int n = 0; n < 60; n++) begin
      int kind;
      bit rd, wr;
      logic [2:0] f3;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      rd = (kind < 5);
      wr = (kind >= 5) && (kind < 9);
      if ($urandom_range(0, 9) < 8) f3 = wr ? 3'($urandom_range(0, 2)) : legal_ld[$urandom_range(0, 4)];
      else f3 = 3'($urandom);
      a = $urandom;
      if ($urandom_range(0, 9) < 6) a[1:0] = 2'b00;
      do_access("rand", rd, wr, a, $urandom, f3, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), $urandom);
    end
  endtask

  initial begin
    test_reset;
    test_load_store;
    test_fault;
    test_same_cycle;
    test_reset_mid;
    test_random;
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0; mem_rvalid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
